mem_arbiter: RTL and testbench

//   Shares one single-port synchronous memory between the instruction-fetch port (i_*)
//   and the load/store port (d_*) of the multicycle CPU.

---
 rtl/mem_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin sharing of one single-port synchronous memory between the fetch port
// and the load/store port; sequences each access and formats byte lanes for lb/sb.
module mem_arbiter #(
    parameter int ADDR_W  = 10,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [31:0]       i_addr,
    output logic              i_ack,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic              d_bmode,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ack,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    output logic              m_en,
    output logic              m_we,
    output logic [3:0]        m_be,
    output logic [ADDR_W-1:0] m_addr,
    output logic [31:0]       m_wdata,
    input  logic [31:0]       m_rdata
);
    localparam int   CNT_W      = $clog2(MEM_LAT + 1);
    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_DATA  = 1'b1;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              r_port;
    logic              r_last_grant;
    logic              r_we;
    logic              r_bmode;
    logic              r_err;
    logic [ADDR_W+1:0] r_addr;
    logic [3:0]        r_be;
    logic [31:0]       r_wdata;
    logic [31:0]       r_i_rdata;
    logic [31:0]       r_d_rdata;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_grant;
    logic              w_grant_data;
    logic              w_misalign;
    logic              w_capture;
    logic              w_last_cnt;
    logic              w_in_access;
    logic [31:0]       w_sel_addr;
    logic [31:0]       w_load_data;
    logic [7:0]        w_lane [4];
    logic              w_unused;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign w_lane[gi] = m_rdata[8*gi +: 8];
        end
    endgenerate

    assign w_load_data = r_bmode ? {{24{w_lane[r_addr[1:0]][7]}}, w_lane[r_addr[1:0]]}
                                 : m_rdata;
    assign w_sel_addr  = w_grant_data ? d_addr : i_addr;
    // Address bits above the memory size alias onto the same words.
    assign w_unused    = ^w_sel_addr[31:ADDR_W+2];
    assign w_last_cnt  = (r_cnt == CNT_W'(MEM_LAT));
    assign w_in_access = (r_state == S_ACCESS);

    always_comb begin
        w_state_next = r_state;
        w_grant      = 1'b0;
        w_grant_data = 1'b0;
        w_misalign   = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_req || d_req) begin
                    w_grant      = 1'b1;
                    w_grant_data = d_req && (!i_req || (r_last_grant == PORT_FETCH));
                    w_misalign   = w_grant_data && !d_bmode && (d_addr[1:0] != 2'b00);
                    w_state_next = w_misalign ? S_RESP : S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (w_last_cnt) begin
                    w_capture    = 1'b1;
                    w_state_next = S_RESP;
                end
            end
            S_RESP:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_port       <= PORT_FETCH;
            r_last_grant <= PORT_DATA;
            r_we         <= 1'b0;
            r_bmode      <= 1'b0;
            r_err        <= 1'b0;
            r_addr       <= '0;
            r_be         <= '0;
            r_wdata      <= '0;
            r_i_rdata    <= '0;
            r_d_rdata    <= '0;
            r_cnt        <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_grant) begin
                r_port       <= w_grant_data;
                r_last_grant <= w_grant_data;
                r_we         <= w_grant_data && d_we;
                r_bmode      <= w_grant_data && d_bmode;
                r_err        <= w_misalign;
                r_addr       <= w_sel_addr[ADDR_W+1:0];
                r_cnt        <= '0;
                r_be         <= (w_grant_data && d_bmode) ? (4'b0001 << d_addr[1:0]) : 4'b1111;
                // Byte stores replicate the byte so every lane carries it.
                r_wdata      <= !w_grant_data ? 32'h0 :
                                d_bmode       ? {4{d_wdata[7:0]}} : d_wdata;
            end else if (w_in_access) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_capture) begin
                if (r_port == PORT_FETCH) begin
                    r_i_rdata <= m_rdata;
                end else if (!r_we) begin
                    r_d_rdata <= w_load_data;
                end
            end
        end
    end

    assign m_en    = w_in_access;
    assign m_we    = w_in_access && r_we && (r_cnt == '0);
    assign m_be    = w_in_access ? r_be : 4'b0000;
    assign m_addr  = w_in_access ? r_addr[ADDR_W+1:2] : '0;
    assign m_wdata = w_in_access ? r_wdata : 32'h0;

    assign i_ack   = (r_state == S_RESP) && (r_port == PORT_FETCH);
    assign d_ack   = (r_state == S_RESP) && (r_port == PORT_DATA);
    assign d_err   = (r_state == S_RESP) && r_err;
    assign i_rdata = r_i_rdata;
    assign d_rdata = r_d_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized fetch/load/store traffic
// checked against a transaction-level model (grant order, ack timing, memory contents).
module tb_mem_arbiter;
    localparam int AW = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // MEM_LAT=1 instance
    logic        rst, i_req, d_req, d_we, d_bmode;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic        i_ack, d_ack, d_err, m_en, m_we;
    logic [31:0] i_rdata, d_rdata, m_wdata, m_rdata;
    logic [3:0]  m_be;
    logic [AW-1:0] m_addr;

    // MEM_LAT=3 instance (fetch port only exercised)
    logic        rst3, i_req3, d_req3, d_we3, d_bmode3;
    logic [31:0] i_addr3, d_addr3, d_wdata3;
    logic        i_ack3, d_ack3, d_err3, m_en3, m_we3;
    logic [31:0] i_rdata3, d_rdata3, m_wdata3, m_rdata3;
    logic [3:0]  m_be3;
    logic [AW-1:0] m_addr3;

    mem_arbiter #(.ADDR_W(AW), .MEM_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_bmode(d_bmode), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err), .m_en(m_en), .m_we(m_we),
        .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata));

    mem_arbiter #(.ADDR_W(AW), .MEM_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst3), .i_req(i_req3), .i_addr(i_addr3), .i_ack(i_ack3), .i_rdata(i_rdata3),
        .d_req(d_req3), .d_we(d_we3), .d_bmode(d_bmode3), .d_addr(d_addr3), .d_wdata(d_wdata3),
        .d_ack(d_ack3), .d_rdata(d_rdata3), .d_err(d_err3), .m_en(m_en3), .m_we(m_we3),
        .m_be(m_be3), .m_addr(m_addr3), .m_wdata(m_wdata3), .m_rdata(m_rdata3));

    function automatic logic [31:0] init_word(input int i);
        return (i == 4) ? 32'h12345678 : ((32'(i) * 32'h9E3779B9) ^ 32'h00C0FFEE);
    endfunction

    // Memory models: 1-cycle and 3-cycle read latency
    logic        mem_init;
    logic [31:0] mem1 [1024];
    logic [31:0] mem3 [1024];
    logic [31:0] pipe3 [3];
    int          we_cnt1, en_cnt1, en_cnt3;
    logic [3:0]  last_be1;
    logic [31:0] last_wd1;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) mem1[i] <= init_word(i);
            we_cnt1 <= 0;
            en_cnt1 <= 0;
            last_be1 <= 4'h0;
            last_wd1 <= 32'h0;
            m_rdata <= 32'h0;
        end else if (m_en) begin
            m_rdata <= mem1[m_addr];
            en_cnt1 <= en_cnt1 + 1;
            if (m_we) begin
                for (int b = 0; b < 4; b++)
                    if (m_be[b]) mem1[m_addr][8*b +: 8] <= m_wdata[8*b +: 8];
                we_cnt1  <= we_cnt1 + 1;
                last_be1 <= m_be;
                last_wd1 <= m_wdata;
            end
        end
    end

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) mem3[i] <= init_word(i);
            for (int s = 0; s < 3; s++) pipe3[s] <= 32'h0;
            en_cnt3 <= 0;
        end else begin
            if (m_en3) begin
                pipe3[0] <= mem3[m_addr3];
                en_cnt3  <= en_cnt3 + 1;
            end
            pipe3[1] <= pipe3[0];
            pipe3[2] <= pipe3[1];
        end
    end
    assign m_rdata3 = pipe3[2];

    // Reference model state
    logic [31:0] ref_mem [1024];
    logic [31:0] exp_i, exp_d;
    logic        last_d;
    int          n_vec = 0;
    int          n_err = 0;

    // Current operation presented by serve()
    logic [31:0] f_addr_v, d_addr_v, d_wdata_v;
    logic        d_we_v, d_bmode_v;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic model_fetch();
        exp_i = ref_mem[f_addr_v[11:2]];
    endtask

    task automatic model_data();
        logic [9:0]  w;
        logic [1:0]  k;
        logic [7:0]  by;
        w = d_addr_v[11:2];
        k = d_addr_v[1:0];
        if (!d_bmode_v && k != 2'b00) return;
        if (d_we_v) begin
            if (d_bmode_v) ref_mem[w][8*k +: 8] = d_wdata_v[7:0];
            else           ref_mem[w] = d_wdata_v;
        end else if (d_bmode_v) begin
            by    = ref_mem[w][8*k +: 8];
            exp_d = {{24{by[7]}}, by};
        end else begin
            exp_d = ref_mem[w];
        end
    endtask

    // Present requests now (data optionally one cycle later), then follow 10 cycles
    // checking every ack/err against the model's timeline and data.
    task automatic serve(input logic fi, input logic di, input logic dlate, input string tag);
        logic mis, first_d;
        int   t_f, t_d, we0, en0, nwe, nen;
        mis     = di && !d_bmode_v && (d_addr_v[1:0] != 2'b00);
        first_d = di && (!fi || (!dlate && last_d == 1'b0));
        if (first_d) begin
            t_d = mis ? 1 : 3;
            t_f = fi ? t_d + 1 + 3 : 0;
            model_data();
            if (fi) model_fetch();
        end else begin
            t_f = 3;
            t_d = di ? t_f + 1 + (mis ? 1 : 3) : 0;
            model_fetch();
            if (di) model_data();
        end
        last_d = (fi && di) ? !first_d : di;
        nwe = (di && d_we_v && !mis) ? 1 : 0;
        nen = 2 * (int'(fi) + int'(di && !mis));
        we0 = we_cnt1;
        en0 = en_cnt1;
        i_addr  = f_addr_v;
        d_addr  = d_addr_v;
        d_we    = d_we_v;
        d_bmode = d_bmode_v;
        d_wdata = d_wdata_v;
        i_req   = fi;
        d_req   = di && !dlate;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            chk({tag, "_ack_err"}, {29'b0, i_ack, d_ack, d_err},
                {29'b0, fi && (c == t_f), di && (c == t_d), mis && (c == t_d)});
            if (i_ack) begin
                chk({tag, "_i_rdata"}, i_rdata, exp_i);
                i_req = 1'b0;
            end
            if (d_ack) begin
                chk({tag, "_d_rdata"}, d_rdata, exp_d);
                d_req = 1'b0;
            end
            if (dlate && c == 1) d_req = 1'b1;
        end
        chk({tag, "_we_cycles"}, we_cnt1 - we0, nwe);
        chk({tag, "_en_cycles"}, en_cnt1 - en0, nen);
    endtask

    task automatic reset1();
        rst   = 1'b1;
        i_req = 1'b0;
        d_req = 1'b0;
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        last_d = 1'b1;
        exp_i  = 32'h0;
        exp_d  = 32'h0;
    endtask

    initial begin
        logic [31:0] a;
        logic        p0;
        int          lat, en0, seq_n;
        logic [3:0]  seq;
        rst = 1'b1; rst3 = 1'b1; mem_init = 1'b1;
        i_req = 0; d_req = 0; d_we = 0; d_bmode = 0; i_addr = 0; d_addr = 0; d_wdata = 0;
        i_req3 = 0; d_req3 = 0; d_we3 = 0; d_bmode3 = 0; i_addr3 = 0; d_addr3 = 0; d_wdata3 = 0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
        exp_i = 0; exp_d = 0; last_d = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ctrl", {23'b0, i_ack, d_ack, d_err, m_en, m_we, m_be}, 32'h0);
        chk("rst_m_addr", {22'b0, m_addr}, 32'h0);
        chk("rst_m_wdata", m_wdata, 32'h0);
        chk("rst_i_rdata", i_rdata, 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);
        chk("rst3_ctrl", {23'b0, i_ack3, d_ack3, d_err3, m_en3, m_we3, m_be3}, 32'h0);
        mem_init = 1'b0;
        rst = 1'b0; rst3 = 1'b0;
        @(negedge clk);

        // Fetch only
        f_addr_v = 32'h10;
        serve(1'b1, 1'b0, 1'b0, "fetch");
        chk("fetch_word", i_rdata, 32'h12345678);

        // sb then lb at 0x13
        d_we_v = 1'b1; d_bmode_v = 1'b1; d_addr_v = 32'h13; d_wdata_v = 32'h000000AB;
        serve(1'b0, 1'b1, 1'b0, "sb");
        chk("sb_be", {28'b0, last_be1}, 32'h8);
        chk("sb_wdata", last_wd1, 32'hABABABAB);
        d_we_v = 1'b0;
        serve(1'b0, 1'b1, 1'b0, "lb");
        chk("lb_sext", d_rdata, 32'hFFFFFFAB);

        // Misaligned lw
        d_bmode_v = 1'b0; d_addr_v = 32'h06;
        serve(1'b0, 1'b1, 1'b0, "lw_mis");
        chk("lw_mis_hold", d_rdata, 32'hFFFFFFAB);

        // Simultaneous after reset, then both held continuously
        reset1();
        f_addr_v = 32'h40; d_addr_v = 32'h80; d_we_v = 1'b0; d_bmode_v = 1'b0;
        serve(1'b1, 1'b1, 1'b0, "both");
        p0 = ~last_d;
        seq = 4'b0; seq_n = 0;
        i_req = 1'b1; d_req = 1'b1;
        for (int c = 1; c <= 24 && seq_n < 4; c++) begin
            @(negedge clk);
            if (i_ack || d_ack) begin
                seq[seq_n] = d_ack;
                seq_n++;
                if (seq_n == 4) begin
                    i_req = 1'b0;
                    d_req = 1'b0;
                end
            end
        end
        chk("held_count", seq_n, 4);
        chk("held_order", {28'b0, seq}, {28'b0, ~p0, p0, ~p0, p0});
        model_fetch();
        model_data();
        last_d = ~p0;
        repeat (2) @(negedge clk);
        chk("held_quiet", {30'b0, i_ack, d_ack}, 32'h0);

        // Data request arriving during a fetch's ACCESS
        f_addr_v = 32'h44; d_addr_v = 32'h84;
        serve(1'b1, 1'b1, 1'b1, "late_d");

        // Randomized traffic
        for (int it = 0; it < 150; it++) begin
            logic fi, di, dl;
            fi = 1'($urandom_range(0, 1));
            di = 1'($urandom_range(0, 1));
            if (!fi && !di) fi = 1'b1;
            dl = fi && di && ($urandom_range(0, 3) == 0);
            a = $urandom; a[11:2] = 10'($urandom_range(0, 15));
            f_addr_v = a;
            a = $urandom; a[11:2] = 10'($urandom_range(0, 15));
            d_we_v    = 1'($urandom_range(0, 1));
            d_bmode_v = 1'($urandom_range(0, 1));
            if (!d_bmode_v && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            d_addr_v  = a;
            d_wdata_v = $urandom;
            serve(fi, di, dl, "rand");
        end

        // MEM_LAT=3: latency, mid-ACCESS reset, recovery
        en0 = en_cnt3;
        lat = 0;
        i_addr3 = 32'h20; i_req3 = 1'b1;
        for (int c = 1; c <= 10 && lat == 0; c++) begin
            @(negedge clk);
            if (i_ack3) begin
                lat = c;
                i_req3 = 1'b0;
                chk("lat3_rdata", i_rdata3, init_word(8));
            end
        end
        chk("lat3_ack_cycle", lat, 5);
        chk("lat3_en_cycles", en_cnt3 - en0, 4);
        i_addr3 = 32'h24; i_req3 = 1'b1;
        repeat (2) @(negedge clk);
        chk("lat3_mid_en", {31'b0, m_en3}, 32'h1);
        rst3 = 1'b1; i_req3 = 1'b0;
        @(negedge clk);
        rst3 = 1'b0;
        chk("abort_ctrl", {23'b0, i_ack3, d_ack3, d_err3, m_en3, m_we3, m_be3}, 32'h0);
        chk("abort_m_addr", {22'b0, m_addr3}, 32'h0);
        chk("abort_m_wdata", m_wdata3, 32'h0);
        chk("abort_rdata", i_rdata3 | d_rdata3, 32'h0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("abort_quiet", {30'b0, i_ack3, m_en3}, 32'h0);
        end
        lat = 0;
        i_req3 = 1'b1;
        for (int c = 1; c <= 10 && lat == 0; c++) begin
            @(negedge clk);
            if (i_ack3) begin
                lat = c;
                i_req3 = 1'b0;
                chk("recover_rdata", i_rdata3, init_word(9));
            end
        end
        chk("recover_ack_cycle", lat, 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
